// File: rtl/mult_dse_pkg.sv
// Shared types and helpers for the multiplier design-space-exploration checkers.
package mult_dse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest operand the reference product helper accepts.
  localparam int unsigned MAX_WIDTH = 16;

  function automatic int unsigned num_vectors(input int unsigned width);
    return 32'd1 << (32'd2 * width);
  endfunction

  function automatic logic [2*MAX_WIDTH-1:0] exp_product(input logic [MAX_WIDTH-1:0] a,
                                                        input logic [MAX_WIDTH-1:0] b);
    logic [2*MAX_WIDTH-1:0] a_wide;
    logic [2*MAX_WIDTH-1:0] b_wide;
    a_wide = {{MAX_WIDTH{1'b0}}, a};
    b_wide = {{MAX_WIDTH{1'b0}}, b};
    return a_wide * b_wide;
  endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth register pipeline with async active-low reset; depth 0 is a wire.
module delay_line #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst_s;
      assign unused_clk_rst_s = clk ^ rst_n;
      assign q = d;
    end else begin : g_regs
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift register: stage 0 takes the input, each later stage takes its predecessor.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= '0;
          end
        end else begin
          stage_r[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign q = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/multiplier_sweep_checker.sv
// Exhaustively sweeps all operand pairs through a candidate multiplier and
// records the mismatch count plus the first failing vector.
module multiplier_sweep_checker
  import mult_dse_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int DUT_LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  input  logic [2*WIDTH-1:0]   p_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     mismatch_count,
  output logic                 fail_valid,
  output logic [2*WIDTH-1:0]   fail_idx,
  output logic [2*WIDTH-1:0]   fail_p
);

  localparam int          PW       = 2 * WIDTH;
  localparam int unsigned NVEC     = num_vectors(WIDTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(NVEC - 32'd1);
  localparam int          CW       = $clog2(DUT_LATENCY + 1) + 1;
  localparam int          DW       = 1 + PW + PW;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [PW-1:0]          idx_r;
  logic [PW-1:0]          idx_nxt_s;
  logic [CW-1:0]          drain_cnt_r;
  logic [CW-1:0]          drain_cnt_nxt_s;
  logic                   clear_s;

  logic [MAX_WIDTH-1:0]   a_ext_s;
  logic [MAX_WIDTH-1:0]   b_ext_s;
  logic [2*MAX_WIDTH-1:0] exp_full_s;
  logic                   unused_exp_s;
  logic [DW-1:0]          dl_in_s;
  logic [DW-1:0]          dl_out_s;
  logic                   dly_valid_s;
  logic [PW-1:0]          dly_exp_s;
  logic [PW-1:0]          dly_idx_s;

  logic                   mismatch_s;
  logic [PW:0]            count_r;
  logic [PW:0]            count_nxt_s;
  logic                   fail_valid_r;
  logic [PW-1:0]          fail_idx_r;
  logic [PW-1:0]          fail_p_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   pass_r;

  assign a_ext_s      = MAX_WIDTH'(idx_r[PW-1:WIDTH]);
  assign b_ext_s      = MAX_WIDTH'(idx_r[WIDTH-1:0]);
  assign exp_full_s   = exp_product(a_ext_s, b_ext_s);
  assign unused_exp_s = ^exp_full_s;

  // The vector on the outputs is only meaningful while sweeping; valid rides along with it.
  assign dl_in_s = {state_r == RUN, exp_full_s[PW-1:0], idx_r};

  delay_line #(
    .DEPTH (DUT_LATENCY),
    .WIDTH (DW)
  ) u_delay_line (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dl_in_s),
    .q     (dl_out_s)
  );

  assign {dly_valid_s, dly_exp_s, dly_idx_s} = dl_out_s;

  // Next-state logic for the sweep FSM, vector index and drain counter.
  always_comb begin
    state_nxt_s     = state_r;
    idx_nxt_s       = idx_r;
    drain_cnt_nxt_s = drain_cnt_r;
    clear_s         = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s = RUN;
          idx_nxt_s   = '0;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RUN: begin
        if (idx_r == LAST_IDX) begin
          drain_cnt_nxt_s = '0;
          if (DUT_LATENCY > 0) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          idx_nxt_s = idx_r + PW'(1);
        end
      end
      DRAIN: begin
        if (drain_cnt_r == CW'(DUT_LATENCY - 1)) begin
          state_nxt_s = DONE;
        end else begin
          drain_cnt_nxt_s = drain_cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Comparator and mismatch counter; a restart clears the count on the start edge.
  always_comb begin
    mismatch_s  = dly_valid_s && (dly_exp_s != p_in);
    count_nxt_s = count_r;
    if (clear_s) begin
      count_nxt_s = '0;
    end else if (mismatch_s) begin
      count_nxt_s = count_r + (PW+1)'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State, index and drain counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      drain_cnt_r <= '0;
    end else begin
      state_r     <= state_nxt_s;
      idx_r       <= idx_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
    end
  end

  // Result registers; only the first mismatch of a sweep is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r      <= '0;
      fail_valid_r <= 1'b0;
      fail_idx_r   <= '0;
      fail_p_r     <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (clear_s) begin
        fail_valid_r <= 1'b0;
        fail_idx_r   <= '0;
        fail_p_r     <= '0;
      end else if (mismatch_s && !fail_valid_r) begin
        fail_valid_r <= 1'b1;
        fail_idx_r   <= dly_idx_s;
        fail_p_r     <= p_in;
      end else begin
        fail_valid_r <= fail_valid_r;
      end
      busy_r <= (state_nxt_s == RUN) || (state_nxt_s == DRAIN);
      done_r <= (state_nxt_s == DONE);
      pass_r <= (state_nxt_s == DONE) && (count_nxt_s == '0);
    end
  end

  assign a_out          = idx_r[PW-1:WIDTH];
  assign b_out          = idx_r[WIDTH-1:0];
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign mismatch_count = count_r;
  assign fail_valid     = fail_valid_r;
  assign fail_idx       = fail_idx_r;
  assign fail_p         = fail_p_r;

endmodule

// File: tb/tb_multiplier_sweep_checker.sv
// Self-checking bench: two checker instances (latency 0 and 2) driven by behavioural candidates.
module tb_multiplier_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start0, start1;
  logic [1:0] a0, b0, a1, b1;
  logic [3:0] p0, p1;
  logic       busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
  logic [4:0] cnt0, cnt1;
  logic [3:0] fidx0, fp0, fidx1, fp1;

  int         checks = 0;
  int         errors = 0;
  int         mode0;
  int         zero_lat1;
  logic [15:0] fault_set;
  logic [3:0]  fault_xor;
  logic [3:0]  s1, s2;

  multiplier_sweep_checker #(.WIDTH(2), .DUT_LATENCY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_out(a0), .b_out(b0), .p_in(p0),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch_count(cnt0),
    .fail_valid(fv0), .fail_idx(fidx0), .fail_p(fp0));

  multiplier_sweep_checker #(.WIDTH(2), .DUT_LATENCY(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1), .p_in(p1),
    .busy(busy1), .done(done1), .pass(pass1), .mismatch_count(cnt1),
    .fail_valid(fv1), .fail_idx(fidx1), .fail_p(fp1));

  // Candidate multiplier behaviours: 0 correct, 1 stuck-at-0, 2 wrong at 3x3, 3 random fault set.
  function automatic logic [3:0] cand(input int mode, input logic [1:0] a, input logic [1:0] b,
                                      input logic [15:0] fset, input logic [3:0] fxor);
    int p;
    p = int'(a) * int'(b);
    case (mode)
      0: return 4'(p);
      1: return 4'd0;
      2: return (a == 2'd3 && b == 2'd3) ? 4'd0 : 4'(p);
      3: return fset[{a, b}] ? (4'(p) ^ fxor) : 4'(p);
      default: return 4'(p);
    endcase
  endfunction

  always_comb p0 = cand(mode0, a0, b0, fault_set, fault_xor);

  always @(posedge clk) begin
    s1 <= {2'b00, a1} * {2'b00, b1};
    s2 <= s1;
  end
  assign p1 = zero_lat1 ? ({2'b00, a1} * {2'b00, b1}) : s2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Whole-sweep reference: walk every vector and score it like the spec says.
  task automatic ref0(input int mode, output int cnt, output int fv, output int fidx, output int fp);
    cnt = 0; fv = 0; fidx = 0; fp = 0;
    for (int i = 0; i < 16; i++) begin
      int a, b, p;
      a = i / 4; b = i % 4;
      p = int'(cand(mode, 2'(a), 2'(b), fault_set, fault_xor));
      if (p != a * b) begin
        cnt++;
        if (fv == 0) begin fv = 1; fidx = i; fp = p; end
      end
    end
  endtask

  task automatic sweep0(input bit hold, input string tag);
    int cyc, gaps;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = hold;
    check({tag, "_busy_e0"}, busy0, 1);
    check({tag, "_done_e0"}, done0, 0);
    check({tag, "_cnt_e0"}, cnt0, 0);
    cyc = 0; gaps = 0;
    while (!done0 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      if (cyc >= 15) start0 = 1'b0;
      if (!done0 && busy0 !== 1'b1) gaps++;
    end
    check({tag, "_cycles"}, cyc, 16);
    check({tag, "_busy_gap"}, gaps, 0);
    check({tag, "_busy_end"}, busy0, 0);
  endtask

  task automatic sweep1(input string tag);
    int cyc;
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    check({tag, "_busy_e0"}, busy1, 1);
    cyc = 0;
    while (!done1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_cycles"}, cyc, 18);
    check({tag, "_busy_end"}, busy1, 0);
  endtask

  task automatic results0(input string tag, input int mode);
    int ec, ev, ei, ep;
    ref0(mode, ec, ev, ei, ep);
    check({tag, "_cnt"}, cnt0, ec);
    check({tag, "_fv"}, fv0, ev);
    check({tag, "_fidx"}, fidx0, ei);
    check({tag, "_fp"}, fp0, ep);
    check({tag, "_pass"}, pass0, (ec == 0) ? 1 : 0);
    check({tag, "_a_hold"}, a0, 3);
    check({tag, "_b_hold"}, b0, 3);
  endtask

  initial begin
    int zl_cnt;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    mode0 = 0; zero_lat1 = 0; fault_set = '0; fault_xor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    check("rst_a", a0, 0);      check("rst_b", b0, 0);
    check("rst_busy", busy0, 0); check("rst_done", done0, 0);
    check("rst_pass", pass0, 0); check("rst_cnt", cnt0, 0);
    check("rst_fv", fv0, 0);     check("rst_fidx", fidx0, 0);
    check("rst_fp", fp0, 0);

    mode0 = 0; sweep0(1'b0, "correct"); results0("correct", 0);
    mode0 = 1; sweep0(1'b0, "stuck0");  results0("stuck0", 1);
    // restart from DONE must clear the previous nonzero count on the start edge
    mode0 = 2; sweep0(1'b0, "bad33");   results0("bad33", 2);
    check("bad33_cnt_lit", cnt0, 1);
    check("bad33_fidx_lit", fidx0, 15);

    for (int r = 0; r < 4; r++) begin
      fault_set = 16'($urandom);
      fault_xor = 4'($urandom_range(1, 15));
      mode0 = 3; sweep0(1'b0, $sformatf("rand%0d", r)); results0($sformatf("rand%0d", r), 3);
    end

    mode0 = 0; sweep0(1'b1, "hold"); results0("hold", 0);

    // abort mid-sweep with a stuck-at-0 candidate so there is state to lose
    mode0 = 1;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_a", a0, 1); check("mid_b", b0, 3); check("mid_cnt", cnt0, 2);
    rst_n = 1'b0; #1;
    check("arst_a", a0, 0);      check("arst_b", b0, 0);
    check("arst_busy", busy0, 0); check("arst_done", done0, 0);
    check("arst_pass", pass0, 0); check("arst_cnt", cnt0, 0);
    check("arst_fv", fv0, 0);     check("arst_fidx", fidx0, 0);
    check("arst_fp", fp0, 0);
    @(negedge clk); rst_n = 1'b1; mode0 = 0;
    sweep0(1'b0, "post_rst"); results0("post_rst", 0);

    zero_lat1 = 0; sweep1("lat2_ok");
    check("lat2_ok_cnt", cnt1, 0); check("lat2_ok_pass", pass1, 1); check("lat2_ok_fv", fv1, 0);

    // zero-latency candidate under a 2-deep line: vector k is scored against min(k+2,15)
    zl_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      int v;
      v = (k + 2 > 15) ? 15 : k + 2;
      if ((v / 4) * (v % 4) != (k / 4) * (k % 4)) zl_cnt++;
    end
    zero_lat1 = 1; sweep1("lat2_zl");
    check("lat2_zl_cnt", cnt1, zl_cnt); check("lat2_zl_pass", pass1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_sweep_checker.md
# multiplier_sweep_checker

Exhaustive downstream checker for generated candidate multipliers. On `start` it drives every operand pair into the candidate multiplier, compares the candidate's product against the exact unsigned product, and reports a mismatch count and the first failing vector. The RL design-space-exploration flow uses this count as the functional-correctness term of the reward.

## Interface

Parameters:
- `WIDTH`, default 2: operand width of the candidate multiplier. The product is 2*WIDTH bits.
- `DUT_LATENCY`, default 0: number of register stages inside the candidate, from operands to `p_in`.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: begin a sweep. Sampled only in IDLE or DONE.
- `a_out`, out, WIDTH: operand A to the candidate.
- `b_out`, out, WIDTH: operand B to the candidate.
- `p_in`, in, 2*WIDTH: product from the candidate.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: level signal, high in DONE.
- `pass`, out, 1: `done` and `mismatch_count`==0.
- `mismatch_count`, out, 2*WIDTH+1: number of failing vectors.
- `fail_valid`, out, 1: at least one mismatch has been captured.
- `fail_idx`, out, 2*WIDTH: vector index {a,b} of the first mismatch.
- `fail_p`, out, 2*WIDTH: value of `p_in` at the first mismatch.

## Operation

- Vector index `idx` is 2*WIDTH bits. `a_out`=idx[2W-1:W] and `b_out`=idx[W-1:0]. The number of vectors is N=2^(2W), which is 16 at the default.
- The expected product is a*b, unsigned and zero-extended to 2W bits. The comparison with `p_in` is an exact equality.
- The expected value and a valid bit travel through a DUT_LATENCY-deep delay line aligned with the candidate. When DUT_LATENCY=0 the line is a wire.
- States:
  - IDLE: `start`=1 moves to RUN. `idx`, counters and fail capture clear on the same edge.
  - RUN: `idx` increments every cycle. After idx=N-1 is applied, move to DRAIN if DUT_LATENCY>0, otherwise to DONE.
  - DRAIN: lasts DUT_LATENCY cycles with no new vectors. `a_out`/`b_out` hold the last vector. Then move to DONE.
  - DONE: results hold. `start`=1 restarts exactly as from IDLE.
- A comparison happens on every edge where the delayed valid bit is 1:
  - On a mismatch, `mismatch_count` increments.
  - On the first mismatch only, `fail_valid`, `fail_idx` and `fail_p` are captured.
- `start` during RUN or DRAIN is ignored.
- Counter width 2W+1 holds N without overflow. Saturation is not needed.
- Reset values: `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `mismatch_count`=0, `fail_valid`=0, `fail_idx`=0, `fail_p`=0. State is IDLE.
- Asserting `rst_n` mid-sweep aborts immediately and asynchronously to the reset values. No partial result survives. The next `start` runs a full sweep.

## Timing

- Edge E0 samples `start`. Vector k is on `a_out`/`b_out` after edge Ek, for k=0..N-1. All outputs are registered.
- Vector k's result is compared at edge E(k+1+DUT_LATENCY).
- `done` rises after edge E(N+DUT_LATENCY). At the default that is E16, 16 cycles after the start edge.
- `busy` is high from after E0 until `done` rises, with no gap and no overlap.
- `pass` and the counters are stable whenever `done`=1.
- When DUT_LATENCY=0, `p_in` is combinational from `a_out`/`b_out` within one cycle. This is a timing constraint on the candidate and is not checked by this block.

## Structure

- Shared package `mult_dse_pkg`:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - function `num_vectors(WIDTH)`;
  - function `exp_product(a,b)`.
- One sub-module: `delay_line`, parameterised by depth and width, with async active-low reset. Depth 0 is a pass-through. It carries {valid, expected, idx}.
- The top level holds the FSM, the `idx` counter, the comparator and the capture registers.

## Test plan

- Correct combinational model (P=A*B), WIDTH=2: expect `mismatch_count`=0, `pass`=1, `fail_valid`=0, `done` after E16.
- Model with P stuck at 0: expect `mismatch_count`=9 and `fail_idx`=5 (a=1, b=1), `fail_p`=0, `pass`=0.
- Model correct except A=3,B=3 yields 0: expect `mismatch_count`=1, `fail_idx`=15, `fail_p`=0.
- DUT_LATENCY=2 with a correctly pipelined model: expect `pass`=1 and `done` after E18. Swapping in a zero-latency model under the same setting must give mismatches, which checks that alignment is not accidental.
- Drop `rst_n` after vector 7 is applied:
  - all outputs go to zero asynchronously;
  - the next `start` gives a full 16-vector sweep and `pass`=1.
- Hold `start` high through RUN: no restart occurs and `done` still rises at E16. `start` pulsed in DONE clears `mismatch_count` and `done` on the same edge, and a second sweep completes.
